// File: rtl/arbitro_mux2x1.sv
// Two-requester round-robin arbiter for a shared 2:1 mux path.
// Registered grants, a mandatory dead cycle between owners, and a hold timeout.
module arbitro_mux2x1 #(
    parameter int TIMEOUT_CICLOS = 1000,
    parameter int LARGURA_CONT   = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic done0,
    input  logic done1,
    output logic sel,
    output logic gnt0,
    output logic gnt1,
    output logic ocupado,
    output logic timeout
);

    typedef enum logic [1:0] {
        LIVRE    = 2'd0,
        CONCEDE0 = 2'd1,
        CONCEDE1 = 2'd2,
        PAUSA    = 2'd3
    } estado_t;

    localparam bit TIMEOUT_ATIVO = (TIMEOUT_CICLOS > 0);
    localparam logic [LARGURA_CONT-1:0] LIMITE =
        TIMEOUT_ATIVO ? LARGURA_CONT'(TIMEOUT_CICLOS - 1) : '0;

    estado_t                 estado;
    logic                    ultimo;
    logic [LARGURA_CONT-1:0] cont;

    logic vencedor;
    logic req_dono;
    logic req_outro;
    logic done_dono;
    logic estouro;
    logic liberar;

    // Inputs seen from the point of view of whoever currently owns the path.
    // NOTE: every signal gets a value on every path through always_comb, otherwise a latch is inferred.
    always_comb begin
        vencedor  = (req0 && req1) ? ~ultimo : req1;
        req_dono  = (estado == CONCEDE1) ? req1  : req0;
        req_outro = (estado == CONCEDE1) ? req0  : req1;
        done_dono = (estado == CONCEDE1) ? done1 : done0;
        estouro   = TIMEOUT_ATIVO && req_outro && (cont >= LIMITE);
        liberar   = !req_dono || done_dono || estouro;
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado  <= LIVRE;
            sel     <= 1'b0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            ocupado <= 1'b0;
            timeout <= 1'b0;
            ultimo  <= 1'b1;
            cont    <= '0;
        end else begin
            timeout <= 1'b0;
            case (estado)
                LIVRE: begin
                    if (req0 || req1) begin
                        estado  <= vencedor ? CONCEDE1 : CONCEDE0;
                        sel     <= vencedor;
                        gnt0    <= ~vencedor;
                        gnt1    <= vencedor;
                        ocupado <= 1'b1;
                        ultimo  <= vencedor;
                        cont    <= '0;
                    end
                end
                CONCEDE0, CONCEDE1: begin
                    if (liberar) begin
                        estado  <= PAUSA;
                        gnt0    <= 1'b0;
                        gnt1    <= 1'b0;
                        ocupado <= 1'b0;
                        // A forced revoke that coincides with a normal release is not reported.
                        timeout <= estouro && req_dono && !done_dono;
                    end else if (req_outro) begin
                        if (cont != '1) begin
                            cont <= cont + 1'b1;
                        end
                    end else begin
                        cont <= '0;
                    end
                end
                PAUSA: begin
                    estado <= LIVRE;
                end
                default: begin
                    estado <= LIVRE;
                end
            endcase
        end
    end

    a_exclusivo: assert property (@(posedge clock) disable iff (reset) !(gnt0 && gnt1));
    a_ocupado:   assert property (@(posedge clock) disable iff (reset) ocupado == (gnt0 || gnt1));
    a_sel:       assert property (@(posedge clock) disable iff (reset) (gnt0 || gnt1) |-> (sel == gnt1));

endmodule

// File: tb/tb_arbitro_mux2x1.sv
// Bench for arbitro_mux2x1: ownership-level reference model checked every cycle,
// plus directed scenarios with literal expectations and a randomized soak.
module tb_arbitro_mux2x1;

    localparam int T = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic req0  = 1'b0;
    logic req1  = 1'b0;
    logic done0 = 1'b0;
    logic done1 = 1'b0;
    logic sel, gnt0, gnt1, ocupado, timeout;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    arbitro_mux2x1 #(
        .TIMEOUT_CICLOS(T),
        .LARGURA_CONT  (3)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .req0   (req0),
        .req1   (req1),
        .done0  (done0),
        .done1  (done1),
        .sel    (sel),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .ocupado(ocupado),
        .timeout(timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string nome, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nome, got, exp, $time);
        end
    endtask

    // Reference model: owner (-1 = nobody), contested-cycle run length, dead-cycle flag.
    int m_owner = -1;
    int m_run   = 0;
    int m_last  = 1;
    bit m_dead  = 1'b0;
    bit m_sel   = 1'b0;
    bit m_to    = 1'b0;

    initial forever begin
        @(posedge clock);
        m_to = 1'b0;
        if (reset) begin
            m_owner = -1;
            m_run   = 0;
            m_last  = 1;
            m_dead  = 1'b0;
            m_sel   = 1'b0;
        end else if (m_owner >= 0) begin
            bit own_req, own_done, other_req;
            own_req   = (m_owner == 0) ? req0  : req1;
            own_done  = (m_owner == 0) ? done0 : done1;
            other_req = (m_owner == 0) ? req1  : req0;
            m_run = other_req ? m_run + 1 : 0;
            if (!own_req || own_done) begin
                m_owner = -1;
                m_dead  = 1'b1;
            end else if (T > 0 && m_run >= T) begin
                m_owner = -1;
                m_dead  = 1'b1;
                m_to    = 1'b1;
            end
        end else if (m_dead) begin
            m_dead = 1'b0;
        end else if (req0 || req1) begin
            if (req0 && req1) m_owner = 1 - m_last;
            else              m_owner = req0 ? 0 : 1;
            m_last = m_owner;
            m_sel  = (m_owner == 1);
            m_run  = 0;
        end
    end

    always @(negedge clock) begin
        if (chk_on) begin
            check("model_gnt0",    gnt0,    m_owner == 0);
            check("model_gnt1",    gnt1,    m_owner == 1);
            check("model_ocupado", ocupado, m_owner >= 0);
            check("model_sel",     sel,     m_sel);
            check("model_timeout", timeout, m_to);
            check("inv_exclusivo", gnt0 & gnt1, 1'b0);
            check("inv_ocupado",   ocupado, gnt0 | gnt1);
            if (gnt0 || gnt1) check("inv_sel", sel, gnt1);
        end
    end

    task automatic ciclo(input logic r0, input logic r1, input logic d0, input logic d1);
        req0  = r0;
        req1  = r1;
        done0 = d0;
        done1 = d1;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ciclo(0, 0, 0, 0);
        reset = 1'b0;
    endtask

    initial begin
        ciclo(0, 0, 0, 0);
        ciclo(0, 0, 0, 0);
        chk_on = 1'b1;
        check("rst_gnt0", gnt0, 1'b0);
        check("rst_gnt1", gnt1, 1'b0);
        check("rst_sel", sel, 1'b0);
        check("rst_ocupado", ocupado, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        reset = 1'b0;

        // Single requester, then a PAUSA glitch that must not be latched.
        ciclo(1, 0, 0, 0);
        check("t1_gnt0", gnt0, 1'b1);
        check("t1_sel", sel, 1'b0);
        check("t1_ocupado", ocupado, 1'b1);
        for (int i = 0; i < 4; i++) ciclo(1, 0, 0, 0);
        check("t1_hold", gnt0, 1'b1);
        ciclo(0, 0, 0, 0);
        check("t1_drop", gnt0, 1'b0);
        check("t1_drop_ocupado", ocupado, 1'b0);
        ciclo(0, 1, 0, 0);
        check("t1_pausa", gnt1, 1'b0);
        ciclo(0, 0, 0, 0);
        check("t1_glitch", gnt1, 1'b0);

        // Contention alternates 0, 1, 0 with one dead cycle between owners.
        do_reset();
        ciclo(1, 1, 0, 0);
        check("t2_first_gnt0", gnt0, 1'b1);
        ciclo(1, 1, 0, 0);
        ciclo(0, 1, 0, 0);
        check("t2_drop0", gnt0, 1'b0);
        ciclo(0, 1, 0, 0);
        check("t2_dead", gnt1, 1'b0);
        ciclo(1, 1, 0, 0);
        check("t2_gnt1", gnt1, 1'b1);
        check("t2_sel1", sel, 1'b1);
        ciclo(1, 0, 0, 0);
        check("t2_drop1", gnt1, 1'b0);
        check("t2_sel_kept", sel, 1'b1);
        ciclo(1, 1, 0, 0);
        ciclo(1, 1, 0, 0);
        check("t2_gnt0_again", gnt0, 1'b1);
        check("t2_sel0", sel, 1'b0);
        ciclo(0, 0, 0, 0);
        ciclo(0, 0, 0, 0);

        // Timeout with both requesters stuck high; last round released by done0.
        do_reset();
        ciclo(1, 1, 0, 0);
        check("t3_gnt0", gnt0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            ciclo(1, 1, 0, 0);
            check("t3_held0", gnt0, 1'b1);
            check("t3_no_to0", timeout, 1'b0);
        end
        ciclo(1, 1, 0, 0);
        check("t3_revoke0", gnt0, 1'b0);
        check("t3_timeout0", timeout, 1'b1);
        ciclo(1, 1, 0, 0);
        check("t3_to_pulse", timeout, 1'b0);
        check("t3_dead", gnt1, 1'b0);
        ciclo(1, 1, 0, 0);
        check("t3_gnt1", gnt1, 1'b1);
        check("t3_sel1", sel, 1'b1);
        for (int i = 0; i < 3; i++) ciclo(1, 1, 0, 0);
        check("t3_held1", gnt1, 1'b1);
        ciclo(1, 1, 0, 0);
        check("t3_revoke1", gnt1, 1'b0);
        check("t3_timeout1", timeout, 1'b1);
        ciclo(1, 1, 0, 0);
        ciclo(1, 1, 0, 0);
        check("t3_gnt0_back", gnt0, 1'b1);
        for (int i = 0; i < 3; i++) ciclo(1, 1, 0, 0);
        ciclo(1, 1, 1, 0);
        check("t3_done_drop", gnt0, 1'b0);
        check("t3_done_no_to", timeout, 1'b0);
        ciclo(0, 0, 0, 0);
        ciclo(0, 0, 0, 0);

        // done1 release, re-grant, ignored done0, then hand-over to req0.
        do_reset();
        ciclo(0, 1, 0, 0);
        check("t4_gnt1", gnt1, 1'b1);
        ciclo(0, 1, 0, 0);
        ciclo(0, 1, 0, 1);
        check("t4_done1", gnt1, 1'b0);
        ciclo(0, 1, 0, 0);
        check("t4_pausa", gnt1, 1'b0);
        ciclo(0, 1, 0, 0);
        check("t4_regrant", gnt1, 1'b1);
        ciclo(0, 1, 1, 0);
        check("t4_done0_ignored", gnt1, 1'b1);
        ciclo(1, 1, 0, 1);
        check("t4_done1_again", gnt1, 1'b0);
        ciclo(1, 1, 0, 0);
        ciclo(1, 1, 0, 0);
        check("t4_gnt0", gnt0, 1'b1);

        // Reset while gnt1 is held.
        do_reset();
        ciclo(0, 1, 0, 0);
        ciclo(0, 1, 0, 0);
        check("t5_gnt1", gnt1, 1'b1);
        reset = 1'b1;
        ciclo(1, 1, 0, 0);
        check("t5_rst_gnt1", gnt1, 1'b0);
        check("t5_rst_sel", sel, 1'b0);
        check("t5_rst_ocupado", ocupado, 1'b0);
        reset = 1'b0;
        ciclo(1, 1, 0, 0);
        check("t5_gnt0_first", gnt0, 1'b1);

        // Randomized soak against the model and invariants.
        for (int i = 0; i < 10000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            ciclo($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
        end
        reset = 1'b0;
        ciclo(0, 0, 0, 0);
        ciclo(0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
